// File: rtl/conv_pkg.sv
// Shared encodings for the conv sequencer: host commands, buffer selects and FSM states.
package conv_pkg;

    localparam logic [2:0] CMD_CLEAR     = 3'd0;
    localparam logic [2:0] CMD_LOAD_FEAT = 3'd1;
    localparam logic [2:0] CMD_LOAD_BIAS = 3'd2;
    localparam logic [2:0] CMD_LOAD_WGT  = 3'd3;
    localparam logic [2:0] CMD_RUN_CONV  = 3'd4;

    localparam logic [1:0] SEL_FEAT = 2'd0;
    localparam logic [1:0] SEL_BIAS = 2'd1;
    localparam logic [1:0] SEL_WGT  = 2'd2;

    localparam int MAC_LAT_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_RUN,
        ST_WAIT
    } state_e;

    function automatic logic [1:0] buf_sel_of(logic [2:0] cmd);
        case (cmd)
            CMD_LOAD_BIAS: return SEL_BIAS;
            CMD_LOAD_WGT:  return SEL_WGT;
            default:       return SEL_FEAT;
        endcase
    endfunction

endpackage

// File: rtl/conv_seq_delay.sv
// Fixed-latency shift line that carries {mac_last, mac_row} until the MAC result is ready.
module conv_seq_delay #(
    parameter int LAT = 3,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe_q [LAT];
    logic [W-1:0] pipe_d [LAT];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[LAT-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Conv sequencer: turns register-block commands into memory-to-buffer loads and the MAC sweep,
// and reports sticky completion flags back to the register block.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int            AW        = 16,
    parameter logic [AW-1:0] FEAT_BASE = 16'h0000,
    parameter logic [AW-1:0] BIAS_BASE = 16'h0400,
    parameter logic [AW-1:0] WGT_BASE  = 16'h0800,
    parameter int            MAC_LAT   = MAC_LAT_DEFAULT
) (
    input  logic          PCLK,
    input  logic          PRESETB,
    input  logic [2:0]    command,
    input  logic [8:0]    input_len_ex,
    input  logic [8:0]    output_len_ex,
    input  logic [8:0]    width_ex,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    output logic          buf_we,
    output logic [1:0]    buf_sel,
    output logic [AW-1:0] buf_waddr,
    output logic          mac_valid,
    output logic          mac_first,
    output logic          mac_last,
    output logic [AW-1:0] mac_feat_addr,
    output logic [AW-1:0] mac_wgt_addr,
    output logic [8:0]    mac_row,
    output logic          out_we,
    output logic [8:0]    out_addr,
    output logic          feature_read_done,
    output logic          bias_read_done,
    output logic          weight_read_done,
    output logic          conv_done
);

    state_e        state_q, state_d;
    logic [2:0]    cmd_q, cmd_d, op_q, op_d;
    logic [17:0]   n_q, n_d, idx_q, idx_d;
    logic [8:0]    row_q, row_d, col_q, col_d, rows_q, rows_d, width_q, width_d;
    logic          rd_vld_q, rd_vld_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [3:0]    done_q, done_d;
    logic          start, clear;
    logic [17:0]   n_load;
    logic [AW-1:0] base;
    logic [9:0]    dly_out;

    // done bit order: 0 feature, 1 bias, 2 weight, 3 conv
    always_comb begin
        cmd_d    = command;
        state_d  = state_q;
        op_d     = op_q;
        n_d      = n_q;
        idx_d    = idx_q;
        row_d    = row_q;
        col_d    = col_q;
        rows_d   = rows_q;
        width_d  = width_q;
        done_d   = done_q;
        rd_vld_d = mem_rd_en;
        rd_idx_d = AW'(idx_q);
        n_load   = '0;
        start    = (state_q == ST_IDLE) && (command != cmd_q);
        clear    = (command == CMD_CLEAR) && (cmd_q != CMD_CLEAR);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (command)
                        CMD_LOAD_FEAT, CMD_LOAD_BIAS, CMD_LOAD_WGT: begin
                            case (command)
                                CMD_LOAD_FEAT: n_load = 18'(input_len_ex);
                                CMD_LOAD_BIAS: n_load = 18'(output_len_ex);
                                default:       n_load = 18'(output_len_ex) * 18'(width_ex);
                            endcase
                            op_d  = command;
                            n_d   = n_load;
                            idx_d = '0;
                            done_d[command[1:0] - 2'd1] = 1'b0;
                            state_d = (n_load == '0) ? ST_DRAIN : ST_LOAD;
                        end
                        CMD_RUN_CONV: begin
                            op_d      = command;
                            rows_d    = output_len_ex;
                            width_d   = width_ex;
                            row_d     = '0;
                            col_d     = '0;
                            idx_d     = '0;
                            done_d[3] = 1'b0;
                            state_d = (output_len_ex == '0 || width_ex == '0) ? ST_DRAIN : ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                idx_d = idx_q + 18'd1;
                if (idx_q == n_q - 18'd1) state_d = ST_DRAIN;
            end
            // DRAIN covers the read-return cycle of the last word before the flag rises
            ST_DRAIN: begin
                state_d = ST_IDLE;
                case (op_q)
                    CMD_LOAD_FEAT: done_d[0] = 1'b1;
                    CMD_LOAD_BIAS: done_d[1] = 1'b1;
                    CMD_LOAD_WGT:  done_d[2] = 1'b1;
                    default:       done_d[3] = 1'b1;
                endcase
            end
            ST_RUN: begin
                idx_d = idx_q + 18'd1;
                if (col_q == width_q - 9'd1) begin
                    col_d = '0;
                    row_d = row_q + 9'd1;
                    if (row_q == rows_q - 9'd1) state_d = ST_WAIT;
                end else begin
                    col_d = col_q + 9'd1;
                end
            end
            ST_WAIT: begin
                if (out_we && out_addr == rows_q - 9'd1) begin
                    done_d[3] = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) done_d = '0;
    end

    always_comb begin
        case (op_q)
            CMD_LOAD_BIAS: base = BIAS_BASE;
            CMD_LOAD_WGT:  base = WGT_BASE;
            default:       base = FEAT_BASE;
        endcase
    end

    // Every datapath-facing output is forced to zero when its strobe is low
    assign mem_rd_en     = (state_q == ST_LOAD);
    assign mem_rd_addr   = mem_rd_en ? base + AW'(idx_q) : '0;
    assign buf_we        = rd_vld_q;
    assign buf_sel       = buf_we ? buf_sel_of(op_q) : '0;
    assign buf_waddr     = buf_we ? rd_idx_q : '0;
    assign mac_valid     = (state_q == ST_RUN);
    assign mac_first     = mac_valid && (col_q == '0);
    assign mac_last      = mac_valid && (col_q == width_q - 9'd1);
    assign mac_feat_addr = mac_valid ? AW'(col_q) : '0;
    assign mac_wgt_addr  = mac_valid ? AW'(idx_q) : '0;
    assign mac_row       = mac_valid ? row_q : '0;

    conv_seq_delay #(
        .LAT (MAC_LAT),
        .W   (10)
    ) u_delay (
        .clk   (PCLK),
        .rst_n (PRESETB),
        .din   ({mac_last, mac_row}),
        .dout  (dly_out)
    );

    assign out_we   = dly_out[9];
    assign out_addr = out_we ? dly_out[8:0] : '0;

    assign feature_read_done = done_q[0];
    assign bias_read_done    = done_q[1];
    assign weight_read_done  = done_q[2];
    assign conv_done         = done_q[3];

    always_ff @(posedge PCLK or negedge PRESETB) begin
        if (!PRESETB) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            op_q     <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            rows_q   <= '0;
            width_q  <= '0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            op_q     <= op_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rows_q   <= rows_d;
            width_q  <= width_d;
            rd_vld_q <= rd_vld_d;
            rd_idx_q <= rd_idx_d;
            done_q   <= done_d;
        end
    end

endmodule
